// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies and the divide-by-zero result constant.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_CNT_W           = 4;
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu, including
// the divide-by-zero and signed-overflow special cases.
module md_calc
    import md_pkg::*;
(
    input  logic [1:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic        [31:0] div_b_u;
    logic        [31:0] div_b_s;
    logic               div_zero;
    logic               div_ovf;

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Special cases are patched below; keep the dividers on a harmless divisor.
    assign div_b_u = div_zero ? 32'd1 : b;
    assign div_b_s = (div_zero || div_ovf) ? 32'd1 : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign quot_s = $signed(a) / $signed(div_b_s);
    assign rem_s  = $signed(a) % $signed(div_b_s);
    assign quot_u = a / div_b_u;
    assign rem_u  = a % div_b_u;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (md_op_e'(md_op))
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = MD_DIV0_LO;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = MD_DIV0_LO;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at the start edge, held in pending registers and committed after a fixed latency.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mt_we,
    input  logic        mt_hi,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [MD_CNT_W-1:0] MultLoad = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DivLoad  = MD_CNT_W'(DIV_CYCLES);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         pend_hi_q, pend_hi_d;
    logic [31:0]         pend_lo_q, pend_lo_d;
    logic [31:0]         calc_hi;
    logic [31:0]         calc_lo;
    md_state_e           state;

    md_calc u_md_calc (
        .md_op  (md_op),
        .a      (A),
        .b      (B),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    assign state = (cnt_q == '0) ? MD_IDLE : MD_RUN;

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state)
            MD_IDLE: begin
                // start has priority over a simultaneous mthi/mtlo
                if (start) begin
                    pend_hi_d = calc_hi;
                    pend_lo_d = calc_lo;
                    cnt_d     = md_is_div(md_op) ? DivLoad : MultLoad;
                end else if (mt_we) begin
                    if (mt_hi) begin
                        hi_d = A;
                    end else begin
                        lo_d = A;
                    end
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == MD_CNT_W'(1)) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy   = (state == MD_RUN);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = rd_hi ? hi_q : lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- EX-stage multiply/divide unit; sits beside the ALU and takes the same forwarded A/B operands.
- Implements mult, multu, div, divu, mthi, mtlo, and the HI/LO read path for mfhi/mflo.
- Latency is multi-cycle and fixed. A busy flag drives the hazard unit, which stalls the next HI/LO-touching instruction in ID.
- md_out feeds the EX result mux alongside the ALU C output.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches the op in md_op.
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- A  in  32  operand rs (dividend / multiplicand).
- B  in  32  operand rt (divisor / multiplier).
- mt_we  in  1  write A into HI or LO (mthi/mtlo).
- mt_hi  in  1  1 selects HI, 0 selects LO, for mt_we.
- rd_hi  in  1  md_out select: 1 gives HI, 0 gives LO.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  rd_hi ? hi : lo, combinational from registers.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: hi=0, lo=0, busy=0, counter=0, pending regs=0, md_out=0.
- State is a 4-bit counter cnt; busy = (cnt != 0). States:
  - IDLE: cnt==0.
  - RUN: cnt>0.
- IDLE with start=1 at edge T:
  - Compute the full result combinationally from A/B and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - busy rises after edge T.
- RUN:
  - cnt decrements every edge.
  - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, cnt<=0.
  - Busy is high for exactly N cycles. The new hi/lo values are visible in the same cycle busy falls.
- mult: {hi,lo} = 64-bit signed(A) * signed(B).
- multu: {hi,lo} = 64-bit unsigned(A) * unsigned(B).
- div/divu:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - div uses signed interpretation; divu uses unsigned.
- Divide by zero (B==0), both div and divu: lo=0xFFFFFFFF, hi=A. No exception.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mt_we in IDLE: the selected register <= A at the edge. The other register is unchanged.
- Ignored inputs:
  - start while busy is ignored; the hazard unit guarantees this does not occur.
  - mt_we while busy is ignored; the in-flight result wins.
- start and mt_we both high in IDLE: start wins and mt_we is dropped. Treat this as a protocol error; the bench flags it but it must not corrupt state.
- Operands are sampled only at the start edge. A/B changes during RUN have no effect.
- rst_n low mid-operation: the op is aborted immediately and all state returns to reset values. No partial commit.
- md_out is purely combinational on rd_hi/hi/lo, with zero latency. During RUN it shows the old HI/LO.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings (MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11).
  - Default cycle counts.
  - Divide-by-zero result constant 32'hFFFFFFFF.
- One natural sub-module, md_calc: a combinational 64-bit result generator (md_op, A, B -> res_hi, res_lo), including the divide-by-zero and overflow special cases.
- md_unit keeps the counter, pending regs, HI/LO and mt writes.

Test Plan:
- mult A=0xFFFFFFFF, B=0x00000002:
  - busy high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2:
  - busy 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu with the same operands: lo=0x7FFFFFFC, hi=0x00000001.
- Special cases:
  - divu A=0x12345678, B=0: lo=0xFFFFFFFF, hi=0x12345678.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi A=0xAAAA5555 in IDLE:
  - Next cycle hi=0xAAAA5555, lo unchanged.
  - md_out with rd_hi=1 gives 0xAAAA5555.
  - mtlo pulsed during a running mult: ignored; lo takes the mult result.
- Reset abort:
  - Start a div, change A/B mid-run, then pull rst_n low at cycle 4: busy, hi and lo are 0 asynchronously and no later commit occurs.
  - Separately, a start pulse during busy does not restart the counter.
